// File: rtl/mext_mul_sched.sv
// Arbitrates two requesters onto one iterative multiplier; a one-entry product cache lets MUL/MULH pairs skip the multiply.
// Latency: result 1 cycle after accept on a cache hit or illegal op, 1 cycle after mul_fin otherwise; req_ready is held low until the response is taken.
module mext_mul_sched #(
  parameter bit CACHE_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0][2:0]  req_op,
  input  logic [1:0][31:0] req_a,
  input  logic [1:0][31:0] req_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [31:0]      resp_data,
  input  logic             flush,
  output logic             mul_start,
  output logic [2:0]       mul_op,
  output logic [31:0]      mul_a,
  output logic [31:0]      mul_b,
  input  logic             mul_fin,
  input  logic [63:0]      mul_product
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, DRAIN} state_t;
  typedef enum logic [1:0] {CLS_SS, CLS_SU, CLS_UU} cls_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    cls_t        cls;
    logic [63:0] prod;
  } cache_t;

  function automatic cls_t op_class(input logic [2:0] op);
    case (op[1:0])
      2'b10:   op_class = CLS_SU;
      2'b11:   op_class = CLS_UU;
      default: op_class = CLS_SS;
    endcase
  endfunction

  state_t      state;
  logic        rr;
  logic        cache_vld;
  cache_t      cache;

  logic        grant_vld;
  logic        grant_id;
  logic        accept;
  logic [2:0]  sel_op;
  logic [31:0] sel_a;
  logic [31:0] sel_b;
  logic        hit;
  logic [31:0] hit_data;

  always_comb begin
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    case (req_valid)
      2'b01:   grant_vld = 1'b1;
      2'b10: begin
        grant_vld = 1'b1;
        grant_id  = 1'b1;
      end
      2'b11: begin
        grant_vld = 1'b1;
        grant_id  = rr;
      end
      default: ;
    endcase
  end

  // rst gates the grant so nothing is offered while the block is held in reset
  assign accept    = rst && (state == IDLE) && !flush && grant_vld;
  assign req_ready = accept ? (2'b01 << grant_id) : 2'b00;
  assign sel_op    = req_op[grant_id];
  assign sel_a     = req_a[grant_id];
  assign sel_b     = req_b[grant_id];

  // low product half is signedness-independent, so MUL may reuse any class
  assign hit = CACHE_EN && cache_vld && (cache.a == sel_a) && (cache.b == sel_b) &&
               ((sel_op[1:0] == 2'b00) || (cache.cls == op_class(sel_op)));
  assign hit_data = (sel_op[1:0] == 2'b00) ? cache.prod[31:0] : cache.prod[63:32];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      rr         <= 1'b0;
      cache_vld  <= 1'b0;
      cache      <= '0;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_data  <= '0;
      mul_start  <= 1'b0;
      mul_op     <= '0;
      mul_a      <= '0;
      mul_b      <= '0;
    end else begin
      mul_start <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            rr      <= ~grant_id;
            resp_id <= grant_id;
            if (sel_op[2]) begin
              resp_data  <= '0;
              resp_valid <= 1'b1;
              state      <= RESP;
            end else if (hit) begin
              resp_data  <= hit_data;
              resp_valid <= 1'b1;
              state      <= RESP;
            end else begin
              mul_op    <= sel_op;
              mul_a     <= sel_a;
              mul_b     <= sel_b;
              mul_start <= 1'b1;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: state <= flush ? DRAIN : WAIT;
        WAIT: begin
          if (mul_fin) begin
            cache     <= {mul_a, mul_b, op_class(mul_op), mul_product};
            cache_vld <= 1'b1;
            if (flush) begin
              state <= IDLE;
            end else begin
              resp_data  <= (mul_op[1:0] == 2'b00) ? mul_product[31:0] : mul_product[63:32];
              resp_valid <= 1'b1;
              state      <= RESP;
            end
          end else if (flush) begin
            state <= DRAIN;
          end
        end
        RESP: begin
          if (flush || resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        DRAIN: begin
          // multiplier is already running; its product still refreshes the cache
          if (mul_fin) begin
            cache     <= {mul_a, mul_b, op_class(mul_op), mul_product};
            cache_vld <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mext_mul_sched.sv
// Directed bench for mext_mul_sched: the bench drives the multiplier handshake itself with hand-computed products.
module tb_mext_mul_sched;

  localparam logic [2:0] OP_MUL   = 3'b000;
  localparam logic [2:0] OP_MULH  = 3'b001;
  localparam logic [2:0] OP_MULHU = 3'b011;
  localparam logic [2:0] OP_ILL   = 3'b100;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][2:0]  req_op;
  logic [1:0][31:0] req_a;
  logic [1:0][31:0] req_b;
  logic             resp_valid;
  logic             resp_ready;
  logic             resp_id;
  logic [31:0]      resp_data;
  logic             flush;
  logic             mul_start;
  logic [2:0]       mul_op;
  logic [31:0]      mul_a;
  logic [31:0]      mul_b;
  logic             mul_fin;
  logic [63:0]      mul_product;

  logic [1:0]       req_valid1;
  logic [1:0]       req_ready1;
  logic [1:0][2:0]  req_op1;
  logic [1:0][31:0] req_a1;
  logic [1:0][31:0] req_b1;
  logic             resp_valid1;
  logic             resp_ready1;
  logic             resp_id1;
  logic [31:0]      resp_data1;
  logic             mul_start1;
  logic [2:0]       mul_op1;
  logic [31:0]      mul_a1;
  logic [31:0]      mul_b1;
  logic             mul_fin1;
  logic [63:0]      mul_product1;

  int checks = 0;
  int errors = 0;
  int nstart = 0;

  always #5 clk = ~clk;

  mext_mul_sched #(.CACHE_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_data(resp_data),
    .flush(flush),
    .mul_start(mul_start), .mul_op(mul_op), .mul_a(mul_a), .mul_b(mul_b),
    .mul_fin(mul_fin), .mul_product(mul_product)
  );

  mext_mul_sched #(.CACHE_EN(1'b0)) dut_nc (
    .clk(clk), .rst(rst),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_op(req_op1),
    .req_a(req_a1), .req_b(req_b1),
    .resp_valid(resp_valid1), .resp_ready(resp_ready1), .resp_id(resp_id1), .resp_data(resp_data1),
    .flush(1'b0),
    .mul_start(mul_start1), .mul_op(mul_op1), .mul_a(mul_a1), .mul_b(mul_b1),
    .mul_fin(mul_fin1), .mul_product(mul_product1)
  );

  always @(posedge clk) if (mul_start) nstart++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // presents one request at a negedge and returns at the negedge after the accept edge
  task automatic do_req(input int id, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid     = '0;
    req_valid[id] = 1'b1;
    req_op[id]    = op;
    req_a[id]     = a;
    req_b[id]     = b;
    #1 check("grant", req_ready, 64'(2'b01 << id));
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic fin(input logic [63:0] p);
    mul_fin     = 1'b1;
    mul_product = p;
    @(negedge clk);
    mul_fin     = 1'b0;
    mul_product = '0;
  endtask

  task automatic ack();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("ack_idle", resp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; req_valid = 2'b11; req_op = '0; req_a = '0; req_b = '0;
    resp_ready = 1'b0; flush = 1'b0; mul_fin = 1'b0; mul_product = '0;
    req_valid1 = '0; req_op1 = '0; req_a1 = '0; req_b1 = '0;
    resp_ready1 = 1'b0; mul_fin1 = 1'b0; mul_product1 = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", req_ready, 0);
    check("rst_rvld", resp_valid, 0);
    check("rst_rid", resp_id, 0);
    check("rst_rdata", resp_data, 0);
    check("rst_start", mul_start, 0);
    check("rst_mulop", {mul_op, mul_a, mul_b}, 0);
    req_valid = '0;
    rst = 1'b1;
    @(negedge clk);

    // signed MUL miss
    do_req(0, OP_MUL, 32'hFFFF_FFFE, 32'h3);
    check("t1_start", mul_start, 1);
    check("t1_opnds", {mul_op, mul_a, mul_b}, {OP_MUL, 32'hFFFF_FFFE, 32'h3});
    check("t1_novld", resp_valid, 0);
    @(negedge clk);
    check("t1_pulse", mul_start, 0);
    fin(64'hFFFF_FFFF_FFFF_FFFA);
    check("t1_rvld", resp_valid, 1);
    check("t1_rid", resp_id, 0);
    check("t1_rdata", resp_data, 32'hFFFF_FFFA);
    ack();

    // MULH on the same operands hits
    do_req(0, OP_MULH, 32'hFFFF_FFFE, 32'h3);
    check("t2_rvld", resp_valid, 1);
    check("t2_rdata", resp_data, 32'hFFFF_FFFF);
    check("t2_nostart", mul_start, 0);
    ack();
    check("t2_nstart", nstart, 1);

    // MULHU differs in class and misses
    do_req(0, OP_MULHU, 32'hFFFF_FFFE, 32'h3);
    check("t3_start", mul_start, 1);
    check("t3_op", mul_op, OP_MULHU);
    @(negedge clk);
    fin(64'h0000_0002_FFFF_FFFA);
    check("t3_rdata", resp_data, 32'h2);
    ack();
    check("t3_nstart", nstart, 2);

    // MUL from requester 1 hits on the UU entry
    do_req(1, OP_MUL, 32'hFFFF_FFFE, 32'h3);
    check("t4_rvld", resp_valid, 1);
    check("t4_rid", resp_id, 1);
    check("t4_rdata", resp_data, 32'hFFFF_FFFA);
    ack();
    check("t4_nstart", nstart, 2);

    // both requesting, illegal ops, immediate ack: grants alternate
    req_op[0] = OP_ILL; req_op[1] = OP_ILL;
    req_valid = 2'b11; resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 check("arb_rdy", req_ready, (i % 2) ? 2'b10 : 2'b01);
      @(negedge clk);
      check("arb_rid", resp_id, i % 2);
      check("arb_rdata", resp_data, 0);
      @(negedge clk);
    end
    req_valid = '0; resp_ready = 1'b0;
    check("arb_nstart", nstart, 2);

    // response held under backpressure
    do_req(0, OP_MUL, 32'hFFFF_FFFE, 32'h3);
    req_valid = 2'b11;
    for (int i = 0; i < 5; i++) begin
      #1 check("bp_ready", req_ready, 0);
      check("bp_resp", {resp_valid, resp_id, resp_data}, {1'b1, 1'b0, 32'hFFFF_FFFA});
      @(negedge clk);
    end
    req_valid = '0;
    ack();

    // mul_fin while idle is ignored
    mul_fin = 1'b1; mul_product = 64'h1234;
    @(negedge clk);
    mul_fin = 1'b0; mul_product = '0;
    check("fin_idle", resp_valid, 0);

    // flush in IDLE suppresses the accept
    req_valid = 2'b01; req_op[0] = OP_MUL; req_a[0] = 32'd7; req_b[0] = 32'd5; flush = 1'b1;
    #1 check("flidle_rdy", req_ready, 0);
    @(negedge clk);
    flush = 1'b0; req_valid = '0;
    check("flidle_none", {mul_start, resp_valid}, 0);

    // flush in WAIT drains, then an identical MUL hits
    do_req(0, OP_MUL, 32'd7, 32'd5);
    check("flw_start", mul_start, 1);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    req_valid = 2'b01;
    for (int i = 0; i < 3; i++) begin
      #1 check("flw_rdy", req_ready, 0);
      check("flw_rvld", resp_valid, 0);
      @(negedge clk);
    end
    mul_fin = 1'b1; mul_product = 64'd35;
    #1 check("flw_finrdy", req_ready, 0);
    @(negedge clk);
    mul_fin = 1'b0; mul_product = '0;
    #1 check("flw_idlerdy", req_ready, 2'b01);
    check("flw_norsp", resp_valid, 0);
    @(negedge clk);
    req_valid = '0;
    check("flw_hit", {resp_valid, resp_data}, {1'b1, 32'd35});
    check("flw_nstart", nstart, 3);
    ack();

    // flush in RESP drops the result
    do_req(1, 3'b110, 32'd0, 32'd0);
    check("flr_rvld", resp_valid, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flr_drop", resp_valid, 0);

    // async reset between edges while waiting on the multiplier
    do_req(0, OP_MUL, 32'd9, 32'd9);
    @(negedge clk);
    check("ar_wait", mul_a, 32'd9);
    #2 rst = 1'b0;
    #1 check("ar_outs", {resp_valid, resp_id, resp_data, mul_start, mul_op, mul_a, mul_b}, 0);
    check("ar_ready", req_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    req_valid = 2'b11;
    req_op[0] = OP_MUL; req_a[0] = 32'd7; req_b[0] = 32'd5;
    req_op[1] = OP_MUL; req_a[1] = 32'd7; req_b[1] = 32'd5;
    #1 check("ar_rr", req_ready, 2'b01);
    @(negedge clk);
    req_valid = '0;
    check("ar_cache_clr", mul_start, 1);
    @(negedge clk);
    fin(64'd35);
    check("ar_rdata", resp_data, 32'd35);
    ack();

    // with the cache disabled MULH re-issues
    req_valid1 = 2'b01; req_op1[0] = OP_MUL; req_a1[0] = 32'hFFFF_FFFE; req_b1[0] = 32'h3;
    #1 check("nc_grant", req_ready1, 2'b01);
    @(negedge clk);
    req_valid1 = '0;
    check("nc_start1", mul_start1, 1);
    @(negedge clk);
    mul_fin1 = 1'b1; mul_product1 = 64'hFFFF_FFFF_FFFF_FFFA;
    @(negedge clk);
    mul_fin1 = 1'b0; mul_product1 = '0;
    check("nc_rdata", resp_data1, 32'hFFFF_FFFA);
    resp_ready1 = 1'b1;
    @(negedge clk);
    resp_ready1 = 1'b0;
    req_valid1 = 2'b01; req_op1[0] = OP_MULH;
    @(negedge clk);
    req_valid1 = '0;
    check("nc_start2", mul_start1, 1);
    check("nc_nohit", resp_valid1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
